// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line sync, clock glitch filter, 11-bit deframer, timeout.
// Optional macro PS2_RX_PARITY_EN enables odd-parity checking of received frames.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_spa,
    output logic [7:0] o_dap,
    output logic       o_cap,
    output logic       o_err,
    output logic       o_busy
);

    localparam int unsigned FC_W = 8;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BC_W = 3;
`ifdef PS2_RX_PARITY_EN
    localparam logic PARITY_CHECK = 1'b1;
`else
    localparam logic PARITY_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic            r_clk_s1, r_clk_s2;
    logic            r_dat_s1, r_dat_s2;
    logic [FC_W-1:0] r_filt_cnt;
    logic            r_clk_filt;
    logic            r_filt_prev;
    logic            r_fall;
    logic            r_fall_dat;

    state_t          r_state;
    logic [BC_W-1:0] r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;

    state_t          w_state_nx;
    logic [BC_W-1:0] w_bitcnt_nx;
    logic [7:0]      w_shift_nx;
    logic            w_par_nx;
    logic [TO_W-1:0] w_to_cnt_nx;
    logic [7:0]      w_dap_nx;
    logic            w_cap_nx;
    logic            w_err_nx;
    logic            w_timeout;
    logic            w_par_ok;
    logic            w_valid;

    // Two-flop synchronizers, glitch filter and registered falling-edge strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt_cnt  <= '0;
            r_clk_filt  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_fall      <= 1'b0;
            r_fall_dat  <= 1'b1;
        end else begin
            r_clk_s1    <= i_ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= i_ps2_data;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_clk_filt;
            r_fall      <= r_filt_prev & ~r_clk_filt;
            r_fall_dat  <= r_dat_s2;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
                r_filt_cnt <= '0;
                r_clk_filt <= r_clk_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + FC_W'(1);
            end
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
            o_dap    <= '0;
            o_cap    <= 1'b0;
            o_err    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_to_cnt <= w_to_cnt_nx;
            o_dap    <= w_dap_nx;
            o_cap    <= w_cap_nx;
            o_err    <= w_err_nx;
            o_busy   <= (w_state_nx != S_IDLE);
        end
    end

    // An edge in the same cycle as expiry wins, so expiry is masked by r_fall.
    assign w_timeout = (r_state != S_IDLE) && !r_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign w_par_ok  = ^{r_shift, r_par};
    assign w_valid   = r_fall_dat & (w_par_ok | ~PARITY_CHECK);

    // Next-state and output decode.
    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_to_cnt_nx = r_to_cnt;
        w_dap_nx    = o_dap;
        w_cap_nx    = 1'b0;
        w_err_nx    = 1'b0;

        if (r_fall || (r_state == S_IDLE)) begin
            w_to_cnt_nx = '0;
        end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            w_to_cnt_nx = r_to_cnt + TO_W'(1);
        end

        if (r_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_fall_dat) begin
                        w_state_nx  = S_DATA;
                        w_bitcnt_nx = '0;
                        w_shift_nx  = '0;
                    end
                end
                S_DATA: begin
                    w_shift_nx[r_bitcnt] = r_fall_dat;
                    if (r_bitcnt == BC_W'(7)) begin
                        w_state_nx = S_PARITY;
                    end else begin
                        w_bitcnt_nx = r_bitcnt + BC_W'(1);
                    end
                end
                S_PARITY: begin
                    w_par_nx   = r_fall_dat;
                    w_state_nx = S_STOP;
                end
                S_STOP: begin
                    w_state_nx = S_IDLE;
                    if (!w_valid) begin
                        w_err_nx = 1'b1;
                    end else if (i_spa) begin
                        w_dap_nx = r_shift;
                        w_cap_nx = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nx  = S_IDLE;
            w_bitcnt_nx = '0;
            w_shift_nx  = '0;
            w_err_nx    = 1'b1;
        end
    end

endmodule
